obstacle_generator: RTL and testbench

//   Produces the obstacle field consumed by the game logic: spawns up to 10 rectangular

---
 rtl/obstacle_generator.sv | 135 +++++++++++++
 tb/tb_obstacle_generator.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/obstacle_generator.sv
// rtl/obstacle_generator.sv - obstacle field generator: spawns, scrolls and retires up to 10 rectangles
module obstacle_generator #(
  parameter int          SCREEN_W    = 640,
  parameter int          OBS_W       = 40,
  parameter int          SPEED       = 4,
  parameter int          UPPER_BOUND = 20,
  parameter int          LOWER_BOUND = 460,
  parameter int          MIN_H       = 40,
  parameter int          SPAWN_MIN   = 60,
  parameter int          SPAWN_FIRST = 30,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [1:0]   gamemode,
  output logic [199:0] obstacle_x,
  output logic [179:0] obstacle_y,
  output logic [3:0]   active_count
);

  localparam int N = 10;
  localparam logic [9:0]  SPD       = 10'(SPEED);
  localparam logic [9:0]  X_LEFT0   = 10'(SCREEN_W);
  localparam logic [9:0]  X_RIGHT0  = 10'(SCREEN_W + OBS_W - 1);
  localparam logic [10:0] UB        = 11'(UPPER_BOUND);
  localparam logic [10:0] LB        = 11'(LOWER_BOUND);
  localparam logic [10:0] MH        = 11'(MIN_H);
  localparam logic [7:0]  CNT_MIN   = 8'(SPAWN_MIN);
  localparam logic [7:0]  CNT_FIRST = 8'(SPAWN_FIRST);

  logic [9:0]  xl_q [N];
  logic [9:0]  xr_q [N];
  logic [8:0]  yt_q [N];
  logic [8:0]  yb_q [N];
  logic [9:0]  xl_d [N];
  logic [9:0]  xr_d [N];
  logic [8:0]  yt_d [N];
  logic [8:0]  yb_d [N];
  logic [15:0] lfsr_q, lfsr_d;
  logic [7:0]  spawn_cnt_q, spawn_cnt_d;
  logic [3:0]  count_d;
  logic        free_found;
  logic [3:0]  free_idx;
  logic [10:0] height, y_top_s, y_bot_s;

  // Free slot is judged on start-of-cycle state, so a slot retired this edge waits one cycle.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (xr_q[i] == 10'd0) begin
        free_found = 1'b1;
        free_idx   = 4'(i);
      end
    end
    height  = MH + {4'b0, lfsr_q[6:0]};
    y_top_s = UB + {3'b0, lfsr_q[15:8]};
    y_bot_s = y_top_s + height;
    if (y_bot_s > LB) begin
      y_bot_s = LB;
      y_top_s = LB - height;
    end
  end

  always_comb begin
    xl_d        = xl_q;
    xr_d        = xr_q;
    yt_d        = yt_q;
    yb_d        = yb_q;
    lfsr_d      = lfsr_q;
    spawn_cnt_d = spawn_cnt_q;
    count_d     = '0;
    if (gamemode == 2'b01) begin
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      for (int i = 0; i < N; i++) begin
        if (xr_q[i] != 10'd0) begin
          // Landing exactly on x_right==0 retires the slot too, keeping inactive slots all-zero.
          if (xr_q[i] <= SPD) begin
            xl_d[i] = '0;
            xr_d[i] = '0;
            yt_d[i] = '0;
            yb_d[i] = '0;
          end else begin
            xr_d[i] = xr_q[i] - SPD;
            xl_d[i] = (xl_q[i] < SPD) ? 10'd0 : xl_q[i] - SPD;
          end
        end
      end
      if (spawn_cnt_q != 8'd0) begin
        spawn_cnt_d = spawn_cnt_q - 8'd1;
      end else if (free_found) begin
        xl_d[free_idx] = X_LEFT0;
        xr_d[free_idx] = X_RIGHT0;
        yt_d[free_idx] = 9'(y_top_s);
        yb_d[free_idx] = 9'(y_bot_s);
        spawn_cnt_d    = CNT_MIN + {3'b0, lfsr_q[4:0]};
      end
    end
    for (int i = 0; i < N; i++) begin
      count_d = count_d + {3'b0, xr_d[i] != 10'd0};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || gamemode == 2'b00) begin
      for (int i = 0; i < N; i++) begin
        xl_q[i] <= '0;
        xr_q[i] <= '0;
        yt_q[i] <= '0;
        yb_q[i] <= '0;
      end
      lfsr_q       <= LFSR_SEED;
      spawn_cnt_q  <= CNT_FIRST;
      active_count <= '0;
    end else begin
      xl_q         <= xl_d;
      xr_q         <= xr_d;
      yt_q         <= yt_d;
      yb_q         <= yb_d;
      lfsr_q       <= lfsr_d;
      spawn_cnt_q  <= spawn_cnt_d;
      active_count <= count_d;
    end
  end

  always_comb begin
    obstacle_x = '0;
    obstacle_y = '0;
    for (int i = 0; i < N; i++) begin
      obstacle_x[20*i +: 20] = {xr_q[i], xl_q[i]};
      obstacle_y[18*i +: 18] = {yb_q[i], yt_q[i]};
    end
  end

endmodule

// File: tb/tb_obstacle_generator.sv
// tb/tb_obstacle_generator.sv - randomized bench for obstacle_generator against a behavioural model
module tb_obstacle_generator;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   gm;
  logic [199:0] ox [2];
  logic [179:0] oy [2];
  logic [3:0]   ac [2];

  always #5 clk = ~clk;

  obstacle_generator dut_a (
    .clk(clk), .rst_n(rst_n), .gamemode(gm),
    .obstacle_x(ox[0]), .obstacle_y(oy[0]), .active_count(ac[0])
  );

  obstacle_generator #(.SPEED(1), .SPAWN_MIN(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .gamemode(gm),
    .obstacle_x(ox[1]), .obstacle_y(oy[1]), .active_count(ac[1])
  );

  int tests = 0;
  int fails = 0;
  int m_xl [2][10];
  int m_xr [2][10];
  int m_yt [2][10];
  int m_yb [2][10];
  int m_lfsr [2];
  int m_cnt [2];
  int p_speed [2] = '{4, 1};
  int p_smin [2]  = '{60, 1};
  bit chk_en = 1'b0;
  int max_b = 0;

  function automatic int lfsr_next(int v);
    int fb;
    fb = ((v >> 15) ^ (v >> 13) ^ (v >> 12) ^ (v >> 10)) & 1;
    return ((v << 1) & 16'hFFFF) | fb;
  endfunction

  task automatic check(string name, longint act, longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_step(int k);
    int fslot, h, yt, yb;
    if (!rst_n || gm == 2'b00) begin
      for (int i = 0; i < 10; i++) begin
        m_xl[k][i] = 0; m_xr[k][i] = 0; m_yt[k][i] = 0; m_yb[k][i] = 0;
      end
      m_lfsr[k] = 16'hACE1;
      m_cnt[k]  = 30;
    end else if (gm == 2'b01) begin
      fslot = -1;
      for (int i = 0; i < 10; i++)
        if (m_xr[k][i] == 0 && fslot < 0) fslot = i;
      for (int i = 0; i < 10; i++) begin
        if (m_xr[k][i] == 0) continue;
        if (m_xr[k][i] < p_speed[k]) m_xr[k][i] = 0;
        else begin
          m_xr[k][i] -= p_speed[k];
          m_xl[k][i] = (m_xl[k][i] < p_speed[k]) ? 0 : m_xl[k][i] - p_speed[k];
        end
        if (m_xr[k][i] == 0) begin
          m_xl[k][i] = 0; m_yt[k][i] = 0; m_yb[k][i] = 0;
        end
      end
      if (m_cnt[k] != 0) m_cnt[k]--;
      else if (fslot >= 0) begin
        h  = 40 + (m_lfsr[k] & 127);
        yt = 20 + ((m_lfsr[k] >> 8) & 255);
        yb = yt + h;
        if (yb > 460) begin yb = 460; yt = 460 - h; end
        m_xl[k][fslot] = 640; m_xr[k][fslot] = 679;
        m_yt[k][fslot] = yt;  m_yb[k][fslot] = yb;
        m_cnt[k] = p_smin[k] + (m_lfsr[k] & 31);
      end
      m_lfsr[k] = lfsr_next(m_lfsr[k]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
  endtask

  // Single compare process: full outputs of both instances against the model, plus geometry bounds.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        logic [199:0] ex;
        logic [179:0] ey;
        int cnt;
        bit bad;
        ex = '0; ey = '0; cnt = 0; bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
          ex[20*i +: 20] = {10'(m_xr[k][i]), 10'(m_xl[k][i])};
          ey[18*i +: 18] = {9'(m_yb[k][i]), 9'(m_yt[k][i])};
          if (m_xr[k][i] != 0) cnt++;
        end
        tests++;
        if (ox[k] !== ex || oy[k] !== ey || ac[k] !== 4'(cnt)) begin
          fails++;
          $display("FAIL model_cmp dut%0d t=%0t: x=%h exp %h y=%h exp %h cnt=%0d exp %0d",
                   k, $time, ox[k], ex, oy[k], ey, ac[k], cnt);
        end
        for (int i = 0; i < 10; i++) begin
          int yt, yb;
          yt = int'(oy[k][18*i +: 9]);
          yb = int'(oy[k][18*i+9 +: 9]);
          if (ox[k][20*i+10 +: 10] != 10'd0 &&
              (yt < 20 || yb > 460 || yb - yt < 40)) bad = 1'b1;
        end
        tests++;
        if (bad) begin
          fails++;
          $display("FAIL bounds dut%0d t=%0t: y=%h", k, $time, oy[k]);
        end
      end
      if (int'(ac[1]) > max_b) max_b = int'(ac[1]);
    end
  end

  initial begin
    int y0_top, y0_bot, r, pause_left;
    logic [1:0] pause_mode;

    check("lfsr_step_pin", lfsr_next(16'hACE1), 16'h59C3);

    rst_n = 1'b0; gm = 2'b01;
    tick();
    chk_en = 1'b1;
    check("reset_x", ox[0], 0);
    check("reset_y", oy[0], 0);
    check("reset_cnt", ac[0], 0);

    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) tick();
    check("no_spawn_30", ac[0], 0);
    tick();
    check("spawn_xl", ox[0][9:0], 640);
    check("spawn_xr", ox[0][19:10], 679);
    check("spawn_cnt1", ac[0], 1);
    y0_top = m_yt[0][0];
    y0_bot = m_yb[0][0];
    tick();
    check("scroll_xl", ox[0][9:0], 636);
    check("scroll_xr", ox[0][19:10], 675);

    for (int i = 0; i < 100; i++) tick();
    gm = 2'b10;
    for (int i = 0; i < 50; i++) tick();
    gm = 2'b11;
    for (int i = 0; i < 50; i++) tick();
    gm = 2'b01;
    for (int i = 0; i < 900; i++) tick();
    check("b_fills_to_10", max_b, 10);

    gm = 2'b00;
    tick();
    check("gm00_x", ox[0], 0);
    check("gm00_y", oy[1], 0);
    check("gm00_cnt", ac[1], 0);
    gm = 2'b01;
    for (int i = 0; i < 30; i++) tick();
    check("rerun_empty", ac[0], 0);
    tick();
    check("rerun_xr", ox[0][19:10], 679);
    check("rerun_ytop", oy[0][8:0], y0_top);
    check("rerun_ybot", oy[0][17:9], y0_bot);

    pause_left = 0;
    pause_mode = 2'b10;
    for (int c = 0; c < 4000; c++) begin
      rst_n = 1'b1;
      if (pause_left > 0) begin
        gm = pause_mode;
        pause_left--;
      end else begin
        r = $urandom_range(0, 9999);
        gm = 2'b01;
        if (r < 3) gm = 2'b00;
        else if (r < 6) rst_n = 1'b0;
        else if (r < 60) begin
          pause_mode = ($urandom_range(0, 1) == 0) ? 2'b10 : 2'b11;
          pause_left = $urandom_range(1, 60);
          gm = pause_mode;
        end else if (r < 70) gm = 2'($urandom_range(0, 3));
      end
      tick();
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
